// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port RAM arbiter between instruction fetch and data load/store
module memory_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int RETRY_MAX  = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [1:0] RETRY_LIM  = 2'(RETRY_MAX);

    state_t      state_q, state_d;
    logic [2:0]  starve_q, starve_d;
    logic [1:0]  retry_q, retry_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic        fault_q, fault_d;

    logic        granted;
    logic        abandon;
    logic        done;
    logic        i_done;
    logic        d_done;
    logic [2:0]  starve_inc;

    assign granted    = (state_q != IDLE);
    assign abandon    = granted && (ramstate == RAM_ERROR) && (retry_q == RETRY_LIM);
    assign done       = granted && ((ramstate == RAM_ACCESS) || abandon);
    assign i_done     = (state_q == IGNT) && done;
    assign d_done     = (state_q == DGNT) && done;
    assign starve_inc = (starve_q == 3'b111) ? starve_q : starve_q + 3'd1;

    // Waits drop combinationally in the owner's completion cycle; the non-owner keeps waiting.
    assign iwait    = iREN && !i_done;
    assign dwait    = (dREN || dWEN) && !d_done;
    assign iload    = (i_done && iREN && !abandon) ? ramload : 32'd0;
    assign dload    = (d_done && dREN && ren_q && !abandon) ? ramload : 32'd0;
    assign ramREN   = (state_q == IGNT) || ((state_q == DGNT) && ren_q);
    assign ramWEN   = (state_q == DGNT) && wen_q;
    assign ramaddr  = granted ? addr_q : 32'd0;
    assign ramstore = granted ? store_q : 32'd0;
    assign fault    = fault_q || abandon;

    // State and request latches; reset aborts any transfer and drops the strobes at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= 3'd0;
            retry_q  <= 2'd0;
            addr_q   <= 32'd0;
            store_q  <= 32'd0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            retry_q  <= retry_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            fault_q  <= fault_d;
        end
    end

    // Retry/fault tracking and grant selection, which runs in IDLE and on every completion.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        retry_d  = retry_q;
        addr_d   = addr_q;
        store_d  = store_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        fault_d  = fault_q;

        if (granted && (ramstate == RAM_ERROR) && !abandon) begin
            retry_d = retry_q + 2'd1;
        end
        if (done) begin
            retry_d = 2'd0;
        end
        if (abandon) begin
            fault_d = 1'b1;
        end

        if ((state_q == IDLE) || done) begin
            if ((dREN || dWEN) && (starve_q < STARVE_LIM)) begin
                state_d  = DGNT;
                addr_d   = daddr;
                store_d  = dstore;
                ren_d    = dREN;
                wen_d    = dWEN;
                starve_d = iREN ? starve_inc : 3'd0;
            end else if (iREN) begin
                state_d  = IGNT;
                addr_d   = iaddr;
                store_d  = 32'd0;
                ren_d    = 1'b1;
                wen_d    = 1'b0;
                starve_d = 3'd0;
            end else begin
                state_d  = IDLE;
                starve_d = 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter
module tb_memory_arbiter;

    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, fault;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks = 0;
    int fails  = 0;

    memory_arbiter #(.STARVE_MAX(4), .RETRY_MAX(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .fault(fault)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          n_busy;
        int          n_err;
        int          exp_cycles;
        logic [31:0] exp_load;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [31:0] load;
        logic        fault;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] script[$];
        int   idx;
        int   cyc;
        bit   done;
        exp_t e;
        for (int i = 0; i < v.n_busy; i++) script.push_back(BUSY);
        for (int i = 0; i < v.n_err; i++) script.push_back(ERR);
        script.push_back(ACC);
        tick();
        if (v.is_d) begin
            dREN = !v.wr; dWEN = v.wr; daddr = v.addr; dstore = v.wdata;
        end else begin
            iREN = 1'b1; iaddr = v.addr;
        end
        ramstate = FREE;
        ramload  = 32'd0;
        sb.push_back('{v.exp_load, v.exp_fault, v.exp_cycles});
        #1;
        chk("idle_no_strobe", {30'd0, ramREN, ramWEN}, 32'd0);
        idx = 0; cyc = 0; done = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
            if (ramREN || ramWEN) begin
                ramstate = (idx < script.size()) ? script[idx] : ACC;
                idx++;
                ramload = v.rdata;
            end else begin
                ramstate = FREE;
            end
            #1;
            if (cyc == 1) begin
                chk("grant_addr", ramaddr, v.addr);
                chk("grant_dir", {30'd0, ramREN, ramWEN}, v.wr ? 32'd1 : 32'd2);
                if (v.wr) chk("grant_store", ramstore, v.wdata);
            end
            if ((v.is_d ? dwait : iwait) == 1'b0) begin
                e = sb.pop_front();
                chk("load", v.is_d ? dload : iload, e.load);
                chk("latency", cyc, e.cycles);
                chk("fault", {31'd0, fault}, {31'd0, e.fault});
                done = 1;
                iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL timeout: wait never dropped for addr %h", v.addr);
            iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
            void'(sb.pop_front());
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h8C220004, 2, 0, 3, 32'h8C220004, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h12345678, 0, 0, 1, 32'h12345678, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h104, 32'hCAFEF00D, 32'h99999999, 1, 0, 2, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h208, 32'h0,        32'hA5A5A5A5, 0, 2, 3, 32'hA5A5A5A5, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h48,  32'h0,        32'h24420001, 1, 1, 3, 32'h24420001, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h20C, 32'h0,        32'h00000077, 0, 3, 3, 32'h0,        1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h4C,  32'h0,        32'h3C010000, 0, 0, 1, 32'h3C010000, 1'b1};

        nRST = 1'b0; iREN = 1'b1; iaddr = 32'h10; dREN = 1'b0; dWEN = 1'b0;
        daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramstate = FREE;

        // reset with a fetch pending
        #12;
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_iwait", {31'd0, iwait}, 32'd1);
        chk("rst_dwait", {31'd0, dwait}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        nRST = 1'b1;
        tick();
        chk("post_rst_ramREN", {31'd0, ramREN}, 32'd1);
        chk("post_rst_ramaddr", ramaddr, 32'h10);
        ramstate = ACC; ramload = 32'h1111;
        #1;
        chk("post_rst_iload", iload, 32'h1111);
        iREN = 1'b0;

        // simultaneous fetch and write: write first, fetch follows with no idle cycle
        tick();
        ramstate = FREE;
        iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        #1;
        chk("both_dwait", {31'd0, dwait}, 32'd1);
        tick();
        ramstate = ACC; ramload = 32'h5555;
        #1;
        chk("both_wr_strobe", {30'd0, ramREN, ramWEN}, 32'd1);
        chk("both_wr_addr", ramaddr, 32'h100);
        chk("both_wr_store", ramstore, 32'hDEADBEEF);
        chk("both_wr_dwait", {31'd0, dwait}, 32'd0);
        chk("both_wr_iwait", {31'd0, iwait}, 32'd1);
        dWEN = 1'b0;
        tick();
        #1;
        chk("both_fetch_strobe", {30'd0, ramREN, ramWEN}, 32'd2);
        chk("both_fetch_addr", ramaddr, 32'h80);
        chk("both_fetch_iload", iload, 32'h5555);
        iREN = 1'b0;
        tick();
        ramstate = FREE;

        foreach (vecs[i]) run_vec(vecs[i]);

        // starvation guard: four data grants, one fetch, repeat
        tick();
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h400; ramstate = FREE;
        for (int g = 0; g < 10; g++) begin
            tick();
            ramstate = ACC; ramload = 32'(g);
            #1;
            chk($sformatf("starve_grant%0d", g), ramaddr, (g % 5 == 4) ? 32'h300 : 32'h400);
        end
        iREN = 1'b0; dREN = 1'b0;
        tick();
        ramstate = FREE;
        #1;
        chk("fault_sticky", {31'd0, fault}, 32'd1);

        // reset mid data grant, with the starve counter at its limit
        tick();
        iREN = 1'b1; iaddr = 32'h500; dREN = 1'b1; daddr = 32'h600;
        for (int g = 0; g < 3; g++) begin
            tick();
            ramstate = ACC;
        end
        tick();
        ramstate = BUSY;
        #1;
        chk("pre_rst_strobe", {30'd0, ramREN, ramWEN}, 32'd2);
        chk("pre_rst_addr", ramaddr, 32'h600);
        nRST = 1'b0;
        #1;
        chk("midrst_strobe", {30'd0, ramREN, ramWEN}, 32'd0);
        chk("midrst_fault", {31'd0, fault}, 32'd0);
        chk("midrst_waits", {30'd0, iwait, dwait}, 32'd3);
        tick();
        nRST = 1'b1;
        tick();
        ramstate = ACC; ramload = 32'hBEEF0001;
        #1;
        chk("post_rst_data_first", ramaddr, 32'h600);
        chk("post_rst_dload", dload, 32'hBEEF0001);
        iREN = 1'b0; dREN = 1'b0;
        tick();
        ramstate = FREE;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
